card_shoe: RTL

- Card source for the blackjack game FSM: the supplying end of the 4-bit card bus the game FSM consumes.
- Holds one 52-card deck, shuffles it with Fisher-Yates driven by a 16-bit LFSR, and deals one card per request.
- Each card is a non-zero value on `card` for exactly one clock; `card` = 0 means no card.

---
 rtl/blackjack_pkg.sv | 43 ++++
 rtl/lfsr16.sv | 35 +++
 rtl/card_shoe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// Shared types and helpers for the blackjack datapath: card encoding, hand limits,
// shoe FSM states and the deck construction / shuffle-mask helpers.
package blackjack_pkg;

   typedef logic [3:0] card_t;

   localparam card_t CARD_NONE  = 4'd0;
   localparam card_t CARD_ACE   = 4'd1;
   localparam card_t CARD_FACE  = 4'd10;

   localparam int HAND_W     = 5;
   localparam int BUST_LIMIT = 21;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      SHOE_IDLE,
      SHOE_FILL,
      SHOE_SHUFFLE,
      SHOE_READY,
      SHOE_DEAL,
      SHOE_EMPTY
   } shoe_state_t;

   // Unshuffled deck order: ranks A..K repeating, J/Q/K collapse to 10.
   function automatic card_t fill_value(input logic [5:0] idx);
      logic [5:0] rank;
      rank = idx % 6'd13;
      if (rank >= 6'd9) fill_value = CARD_FACE;
      else              fill_value = card_t'(rank + 6'd1);
   endfunction

   // Smallest all-ones value covering i, so rejection sampling stays unbiased.
   function automatic logic [5:0] shuffle_mask(input logic [5:0] i);
      if      (i <= 6'd1)  shuffle_mask = 6'd1;
      else if (i <= 6'd3)  shuffle_mask = 6'd3;
      else if (i <= 6'd7)  shuffle_mask = 6'd7;
      else if (i <= 6'd15) shuffle_mask = 6'd15;
      else if (i <= 6'd31) shuffle_mask = 6'd31;
      else                 shuffle_mask = 6'd63;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 0xB400) with seed load and zero-seed substitution,
// so the register can never be left in the all-zero lock-up state.
module lfsr16
   import blackjack_pkg::*;
#(
   parameter logic [15:0] SEED_DEF = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [15:0] seed_i,
   input  logic        advance_i,
   output logic [5:0]  rnd_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = (seed_i == 16'h0000) ? SEED_DEF : seed_i;
      end else if (advance_i) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= SEED_DEF;
      else       lfsr_q <= lfsr_d;
   end

   assign rnd_o = lfsr_q[5:0];

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: fill, Fisher-Yates shuffle from an LFSR, deal one card per request.
// Build option CARD_SHOE_AUTO_RESHUFFLE_EN reshuffles once cards_left <= RESHUFFLE_AT.
module card_shoe
   import blackjack_pkg::*;
#(
   parameter int          RESHUFFLE_AT  = 12,
   parameter logic [15:0] LFSR_SEED_DEF = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        shuffle,
   input  logic [15:0] seed,
   input  logic        req,
   output card_t       card,
   output logic        ready,
   output logic        empty,
   output logic [5:0]  cards_left,
   output shoe_state_t state_dbg
);

   localparam int         DECK_SIZE     = 52;
   localparam logic [5:0] LAST_IDX      = 6'(DECK_SIZE - 1);
   localparam logic [5:0] FULL_COUNT    = 6'(DECK_SIZE);
   localparam logic [5:0] RESHUFFLE_LVL = 6'(RESHUFFLE_AT);
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
   localparam bit AUTO_RESHUFFLE = 1'b1;
`else
   localparam bit AUTO_RESHUFFLE = 1'b0;
`endif

   shoe_state_t state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [5:0]  left_q, left_d;
   card_t       card_q, card_d;
   card_t       deck_q [DECK_SIZE];

   logic       lfsr_load, lfsr_adv, fill_we, swap_en;
   logic [5:0] rnd_w, j_w;

   lfsr16 #(.SEED_DEF(LFSR_SEED_DEF)) u_lfsr (
      .clk_i     (clock),
      .rst_i     (reset),
      .load_i    (lfsr_load),
      .seed_i    (seed),
      .advance_i (lfsr_adv),
      .rnd_o     (rnd_w)
   );

   assign j_w = rnd_w & shuffle_mask(idx_q);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      left_d    = left_q;
      card_d    = CARD_NONE;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      fill_we   = 1'b0;
      swap_en   = 1'b0;
      if (shuffle) begin
         // Shuffle pre-empts everything, including a simultaneous request.
         lfsr_load = 1'b1;
         state_d   = SHOE_FILL;
         idx_d     = 6'd0;
         ptr_d     = 6'd0;
         left_d    = 6'd0;
      end else begin
         unique case (state_q)
            SHOE_FILL: begin
               fill_we = 1'b1;
               if (idx_q == LAST_IDX) state_d = SHOE_SHUFFLE;
               else                   idx_d   = idx_q + 6'd1;
            end
            SHOE_SHUFFLE: begin
               lfsr_adv = 1'b1;
               if (j_w <= idx_q) begin
                  swap_en = 1'b1;
                  idx_d   = idx_q - 6'd1;
                  if (idx_q == 6'd1) begin
                     state_d = SHOE_READY;
                     left_d  = FULL_COUNT;
                     ptr_d   = 6'd0;
                  end
               end
            end
            SHOE_READY: begin
               if (req) begin
                  card_d  = deck_q[ptr_q];
                  ptr_d   = ptr_q + 6'd1;
                  left_d  = left_q - 6'd1;
                  state_d = SHOE_DEAL;
               end
            end
            SHOE_DEAL: begin
               if (AUTO_RESHUFFLE && (left_q <= RESHUFFLE_LVL)) begin
                  state_d = SHOE_FILL;
                  idx_d   = 6'd0;
                  ptr_d   = 6'd0;
                  left_d  = 6'd0;
               end else if (left_q != 6'd0) begin
                  state_d = SHOE_READY;
               end else begin
                  state_d = SHOE_EMPTY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= SHOE_IDLE;
         idx_q   <= 6'd0;
         ptr_q   <= 6'd0;
         left_q  <= 6'd0;
         card_q  <= CARD_NONE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         left_q  <= left_d;
         card_q  <= card_d;
      end
   end

   // Deck storage needs no reset: it is always rebuilt by FILL before use.
   always_ff @(posedge clock) begin
      if (fill_we) begin
         deck_q[idx_q] <= fill_value(idx_q);
      end
      if (swap_en) begin
         deck_q[idx_q] <= deck_q[j_w];
         deck_q[j_w]   <= deck_q[idx_q];
      end
   end

   assign card       = card_q;
   assign ready      = (state_q == SHOE_READY) && (left_q != 6'd0);
   assign empty      = ((state_q != SHOE_READY) && (state_q != SHOE_DEAL)) || (left_q == 6'd0);
   assign cards_left = left_q;
   assign state_dbg  = state_q;

endmodule
